mtr_drv_multi: RTL and testbench



---
 rtl/mtr_drv_multi.sv | 147 ++++++++++++++
 tb/tb_mtr_drv_multi.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mtr_drv_multi.sv
// Multi-channel H-bridge PWM driver: slew-limited signed speed commands,
// complementary outputs with dead-time, coast/brake modes and at-target status.
module mtr_drv_multi #(
    parameter int unsigned NCH  = 2,
    parameter int unsigned W    = 11,
    parameter int unsigned SLEW = 2047,
    parameter int unsigned DB   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             brake,
    input  logic [NCH*W-1:0] speed,
    output logic [NCH-1:0]   pwm1,
    output logic [NCH-1:0]   pwm2,
    output logic [NCH-1:0]   at_target,
    output logic             prd_strb
);
    localparam int unsigned      DTW     = 4;
    localparam logic [W-1:0]     CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0]     HALF    = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W:0] SLEW_S = (W+1)'(SLEW);
    localparam logic [W-1:0]     SLEW_W  = W'(SLEW);
    localparam logic [DTW-1:0]   DT_LOAD = DTW'((DB == 0) ? 0 : DB - 1);

    typedef enum logic [1:0] {
        MODE_COAST,
        MODE_BRAKE,
        MODE_RUN
    } mode_t;

    mode_t                mode_q, mode_d;
    logic [W-1:0]         cnt_q;
    logic                 wrap;
    logic                 reentry;
    logic signed [W-1:0]  cur_q  [NCH];
    logic signed [W-1:0]  cur_d  [NCH];
    logic signed [W-1:0]  tgt    [NCH];
    logic signed [W:0]    diff   [NCH];
    logic [W-1:0]         step   [NCH];
    logic [W-1:0]         duty_q [NCH];
    logic [W-1:0]         duty_d [NCH];
    logic [DTW-1:0]       dt_q   [NCH];
    logic [DTW-1:0]       dt_d   [NCH];
    logic [NCH-1:0]       raw, raw_q;
    logic [NCH-1:0]       pwm1_d, pwm2_d, at_target_d;

    // Mode decode; coast overrides brake.
    always_comb begin
        mode_d = MODE_RUN;
        if (!en) begin
            mode_d = MODE_COAST;
        end else if (brake) begin
            mode_d = MODE_BRAKE;
        end
        wrap    = (cnt_q == CNT_MAX);
        reentry = (mode_q != MODE_RUN);
    end

    // Per-channel clamp, slew step, raw PWM and dead-time output selection.
    always_comb begin
        raw         = '0;
        pwm1_d      = '0;
        pwm2_d      = '0;
        at_target_d = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            tgt[i] = speed[i*W +: W];
            if (tgt[i] == HALF) begin
                tgt[i] = HALF | W'(1);
            end
            diff[i] = {tgt[i][W-1], tgt[i]} - {cur_q[i][W-1], cur_q[i]};
            if (diff[i] > SLEW_S) begin
                step[i] = cur_q[i] + SLEW_W;
            end else if (diff[i] < -SLEW_S) begin
                step[i] = cur_q[i] - SLEW_W;
            end else begin
                step[i] = tgt[i];
            end

            cur_d[i]  = cur_q[i];
            duty_d[i] = duty_q[i];
            dt_d[i]   = dt_q[i];
            raw[i]    = (cnt_q < duty_q[i]);

            case (mode_d)
                MODE_COAST: begin
                    cur_d[i]  = '0;
                    duty_d[i] = HALF;
                    dt_d[i]   = '0;
                end
                MODE_BRAKE: begin
                    dt_d[i]   = '0;
                    pwm1_d[i] = 1'b1;
                    pwm2_d[i] = 1'b1;
                end
                default: begin
                    if (wrap) begin
                        cur_d[i]  = step[i];
                        duty_d[i] = {~step[i][W-1], step[i][W-2:0]};
                    end
                    // Any raw edge, or leaving brake/coast, opens a fresh dead window.
                    if ((raw[i] != raw_q[i] || reentry) && (DB != 0)) begin
                        dt_d[i] = DT_LOAD;
                    end else if (dt_q[i] != '0) begin
                        dt_d[i] = dt_q[i] - DTW'(1);
                    end else begin
                        pwm1_d[i] = raw[i];
                        pwm2_d[i] = ~raw[i];
                    end
                end
            endcase

            at_target_d[i] = (cur_q[i] == tgt[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            mode_q    <= MODE_RUN;
            raw_q     <= '1;
            pwm1      <= '0;
            pwm2      <= '0;
            at_target <= '0;
            prd_strb  <= 1'b0;
            for (int i = 0; i < int'(NCH); i++) begin
                cur_q[i]  <= '0;
                duty_q[i] <= HALF;
                dt_q[i]   <= '0;
            end
        end else begin
            cnt_q     <= cnt_q + W'(1);
            mode_q    <= mode_d;
            raw_q     <= raw;
            pwm1      <= pwm1_d;
            pwm2      <= pwm2_d;
            at_target <= at_target_d;
            prd_strb  <= wrap;
            for (int i = 0; i < int'(NCH); i++) begin
                cur_q[i]  <= cur_d[i];
                duty_q[i] <= duty_d[i];
                dt_q[i]   <= dt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_mtr_drv_multi.sv
// Directed bench for mtr_drv_multi: four instances (default, slew, dead-time,
// four-channel) share clock and reset; pwm high times are counted per period.
module tb_mtr_drv_multi;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        en0, brake0, en1, brake1, en2, brake2, en3, brake3;
    logic [21:0] speed0;
    logic [10:0] speed1, speed2;
    logic [43:0] speed3;
    logic [1:0]  pwm1_0, pwm2_0, at_0;
    logic [0:0]  pwm1_1, pwm2_1, at_1, pwm1_2, pwm2_2, at_2;
    logic [3:0]  pwm1_3, pwm2_3, at_3;
    logic        strb0, strb1, strb2, strb3;

    mtr_drv_multi #(.NCH(2), .W(11), .SLEW(2047), .DB(0)) u0 (
        .clk(clk), .rst(rst), .en(en0), .brake(brake0), .speed(speed0),
        .pwm1(pwm1_0), .pwm2(pwm2_0), .at_target(at_0), .prd_strb(strb0));
    mtr_drv_multi #(.NCH(1), .W(11), .SLEW(100), .DB(0)) u1 (
        .clk(clk), .rst(rst), .en(en1), .brake(brake1), .speed(speed1),
        .pwm1(pwm1_1), .pwm2(pwm2_1), .at_target(at_1), .prd_strb(strb1));
    mtr_drv_multi #(.NCH(1), .W(11), .SLEW(2047), .DB(3)) u2 (
        .clk(clk), .rst(rst), .en(en2), .brake(brake2), .speed(speed2),
        .pwm1(pwm1_2), .pwm2(pwm2_2), .at_target(at_2), .prd_strb(strb2));
    mtr_drv_multi #(.NCH(4), .W(11), .SLEW(2047), .DB(0)) u3 (
        .clk(clk), .rst(rst), .en(en3), .brake(brake3), .speed(speed3),
        .pwm1(pwm1_3), .pwm2(pwm2_3), .at_target(at_3), .prd_strb(strb3));

    // Flat channel map: 0-1 u0, 2 u1, 3 u2, 4-7 u3.
    logic [7:0] p1_all, p2_all, at_all;
    logic [3:0] strb_all;
    assign p1_all   = {pwm1_3, pwm1_2, pwm1_1, pwm1_0};
    assign p2_all   = {pwm2_3, pwm2_2, pwm2_1, pwm2_0};
    assign at_all   = {at_3, at_2, at_1, at_0};
    assign strb_all = {strb3, strb2, strb1, strb0};

    int checks = 0;
    int errors = 0;
    int c1 [8];
    int c2 [8];
    int clow [8];
    int chigh [8];
    int strobes;
    int n;
    logic strb_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the period strobe; n = negedges waited.
    task automatic sync(output int cycles);
        cycles = 0;
        while (cycles < 4096) begin
            @(negedge clk);
            cycles++;
            if (strb0) break;
        end
        chk("sync_strobe_seen", 32'(strb0), 32'd1);
    endtask

    // Count output levels over the 2048 cycles following a strobe cycle.
    task automatic measure();
        for (int k = 0; k < 8; k++) begin
            c1[k] = 0; c2[k] = 0; clow[k] = 0; chigh[k] = 0;
        end
        strobes = 0;
        repeat (2048) begin
            @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                c1[k]    += int'(p1_all[k]);
                c2[k]    += int'(p2_all[k]);
                clow[k]  += int'(!p1_all[k] && !p2_all[k]);
                chigh[k] += int'(p1_all[k] && p2_all[k]);
            end
            strobes += int'(strb0);
        end
        strb_last = strb0;
    endtask

    initial begin
        rst = 1'b1;
        en0 = 1'b1; en1 = 1'b1; en2 = 1'b1; en3 = 1'b1;
        brake0 = 1'b0; brake1 = 1'b0; brake2 = 1'b0; brake3 = 1'b0;
        speed0 = '0; speed1 = '0; speed2 = '0;
        speed3 = {11'd1023, 11'd300, 11'd0, 11'd1548};

        repeat (3) @(negedge clk);
        chk("reset_pwm1", 32'(p1_all), 32'd0);
        chk("reset_pwm2", 32'(p2_all), 32'd0);
        chk("reset_at_target", 32'(at_all), 32'd0);
        chk("reset_prd_strb", 32'(strb_all), 32'd0);
        rst = 1'b0;

        repeat (100) @(negedge clk);
        speed1 = 11'd500;
        sync(n);
        chk("first_strobe_delay", 32'(n), 32'd1948);

        measure(); // period 1
        chk("strobe_count", 32'(strobes), 32'd1);
        chk("strobe_last", 32'(strb_last), 32'd1);
        chk("u0_ch0_pwm1_50pct", 32'(c1[0]), 32'd1024);
        chk("u0_ch0_pwm2_50pct", 32'(c2[0]), 32'd1024);
        chk("u0_ch1_pwm1_50pct", 32'(c1[1]), 32'd1024);
        chk("u0_at_target", 32'(at_0), 32'd3);
        chk("u1_slew_p1", 32'(c1[2]), 32'd1124);
        chk("u1_at_p1", 32'(at_1), 32'd0);
        chk("u2_db_pwm1", 32'(c1[3]), 32'd1021);
        chk("u2_db_pwm2", 32'(c2[3]), 32'd1021);
        chk("u2_db_both_low", 32'(clow[3]), 32'd6);
        chk("u3_ch0_m500", 32'(c1[4]), 32'd524);
        chk("u3_ch1_zero", 32'(c1[5]), 32'd1024);
        chk("u3_ch2_p300", 32'(c1[6]), 32'd1324);
        chk("u3_ch3_p1023", 32'(c1[7]), 32'd2047);
        chk("u3_ch3_pwm2", 32'(c2[7]), 32'd1);
        chk("u3_at_target", 32'(at_3), 32'd15);
        speed0 = {11'd1023, 11'd1024};

        measure(); // period 2: command change not yet applied
        chk("u0_ch0_before_wrap", 32'(c1[0]), 32'd1024);
        chk("u1_slew_p2", 32'(c1[2]), 32'd1224);

        measure(); // period 3
        chk("u0_clamp_neg_pwm1", 32'(c1[0]), 32'd1);
        chk("u0_clamp_neg_pwm2", 32'(c2[0]), 32'd2047);
        chk("u0_clamp_pos_pwm1", 32'(c1[1]), 32'd2047);
        chk("u0_clamp_pos_pwm2", 32'(c2[1]), 32'd1);
        chk("u0_clamp_at_target", 32'(at_0), 32'd3);
        chk("u1_slew_p3", 32'(c1[2]), 32'd1324);

        measure(); // period 4
        chk("u1_slew_p4", 32'(c1[2]), 32'd1424);
        chk("u1_at_p4", 32'(at_1), 32'd0);

        measure(); // period 5
        chk("u1_slew_p5", 32'(c1[2]), 32'd1524);
        chk("u1_at_p5", 32'(at_1), 32'd1);
        en1 = 1'b0;

        measure(); // period 6: coast
        chk("u1_coast_pwm1", 32'(c1[2]), 32'd0);
        chk("u1_coast_pwm2", 32'(c2[2]), 32'd0);
        chk("u1_coast_at", 32'(at_1), 32'd0);
        en1 = 1'b1;

        measure(); // period 7: resume at 50%
        chk("u1_resume_50pct", 32'(c1[2]), 32'd1024);
        measure(); // period 8: ramp from 0
        chk("u1_ramp_from_zero", 32'(c1[2]), 32'd1124);

        repeat (700) @(negedge clk);
        brake0 = 1'b1; speed0 = '0; brake2 = 1'b1;
        @(negedge clk);
        chk("u0_brake_pwm1", 32'(pwm1_0), 32'd3);
        chk("u0_brake_pwm2", 32'(pwm2_0), 32'd3);
        chk("u2_brake_both", 32'({pwm1_2, pwm2_2}), 32'd3);
        sync(n);
        chk("brake_strobe_delay", 32'(n), 32'd1347);
        measure();
        measure();
        chk("u0_ch0_brake_high", 32'(chigh[0]), 32'd2048);
        chk("u0_ch1_brake_high", 32'(chigh[1]), 32'd2048);
        chk("u2_brake_high", 32'(chigh[3]), 32'd2048);
        chk("u0_brake_cur_held", 32'(at_0), 32'd0);

        repeat (700) @(negedge clk);
        brake0 = 1'b0; brake2 = 1'b0;
        @(negedge clk);
        chk("u0_unbrake_pwm1", 32'(pwm1_0), 32'd2);
        chk("u0_unbrake_pwm2", 32'(pwm2_0), 32'd1);
        chk("u2_reentry_low1", 32'({pwm1_2, pwm2_2}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("u2_reentry_low3", 32'({pwm1_2, pwm2_2}), 32'd0);
        @(negedge clk);
        chk("u2_reentry_assert", 32'({pwm1_2, pwm2_2}), 32'd2);
        sync(n);
        measure();
        chk("u0_ch0_after_brake", 32'(c1[0]), 32'd1024);
        chk("u0_ch1_after_brake", 32'(c1[1]), 32'd1024);
        chk("u2_db_after_brake", 32'(c1[3]), 32'd1021);

        repeat (300) @(negedge clk);
        chk("u3_ch3_before_rst", 32'(p1_all[7]), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_pwm1", 32'(p1_all), 32'd0);
        chk("async_rst_pwm2", 32'(p2_all), 32'd0);
        chk("async_rst_at", 32'(at_all), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sync(n);
        chk("restart_strobe_delay", 32'(n), 32'd2048);
        measure();
        chk("u3_ch0_after_rst", 32'(c1[4]), 32'd524);
        chk("u3_ch3_after_rst", 32'(c1[7]), 32'd2047);
        chk("u3_at_after_rst", 32'(at_3), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
